// File: rtl/trng_vn_packer.sv
// trng_vn_packer: multi-channel raw entropy conditioner.
//   Each lane optionally von-Neumann debiases its raw bit stream into a
//   one-bit candidate register and tracks a repetition-count health test.
//   A round-robin merger moves at most one candidate per cycle into a word
//   packer (LSB first), and completed words go into a small output FIFO.
// Ports:
//   clk, reset_n            clock, async active-low reset
//   mode                    0 = bypass, 1 = von Neumann debias
//   ch_enable/raw_valid/raw_bit [CHANNELS]  per-channel raw input
//   clear_fail              clears sticky health failures and run counters
//   out_valid/out_ready/out_word  FIFO head handshake
//   health_fail [CHANNELS]  sticky repetition failure per channel
//   dropped                 pulse: a candidate bit was lost to backpressure

// Per-channel lane: pair state, candidate register, repetition counter.
module trng_vn_lane #(
  parameter int REP_LIMIT = 32
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_mode,
  input  logic i_mode_chg,
  input  logic i_en,
  input  logic i_valid,
  input  logic i_bit,
  input  logic i_clear,
  input  logic i_grant,
  output logic o_cand_valid,
  output logic o_cand_bit,
  output logic o_fail,
  output logic o_drop
);
  localparam int RUN_W = $clog2(REP_LIMIT + 1);

  logic             r_half, r_stored, r_cand_valid, r_cand_bit, r_fail, r_last, r_drop;
  logic [RUN_W-1:0] r_run;
  logic             w_strobe, w_qual, w_half, w_same, w_fail_set, w_prod, w_prod_bit;
  logic [RUN_W-1:0] w_run_inc;

  assign w_strobe = i_valid & i_en;
  assign w_qual   = w_strobe & ~r_fail;
  // A mode change makes any half-collected pair look empty to this cycle's bit.
  assign w_half   = r_half & ~i_mode_chg;
  assign w_same   = (r_run != '0) & (i_bit == r_last);
  // Failure is judged on the uncleared count so a set coinciding with clear wins.
  assign w_fail_set = w_strobe & ~r_fail & w_same & (r_run == RUN_W'(REP_LIMIT - 1));

  always_comb begin
    w_run_inc = r_run;
    if (w_strobe) begin
      if (!w_same)                            w_run_inc = RUN_W'(1);
      else if (r_run != RUN_W'(REP_LIMIT))    w_run_inc = r_run + 1'b1;
    end
  end

  assign w_prod     = w_qual & ~w_fail_set & (i_mode ? (w_half & (r_stored != i_bit)) : 1'b1);
  assign w_prod_bit = i_mode ? r_stored : i_bit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_half       <= 1'b0;
      r_stored     <= 1'b0;
      r_cand_valid <= 1'b0;
      r_cand_bit   <= 1'b0;
      r_fail       <= 1'b0;
      r_last       <= 1'b0;
      r_drop       <= 1'b0;
      r_run        <= '0;
    end else begin
      if (w_strobe) r_last <= i_bit;
      if (!i_en)        r_run <= '0;
      else if (i_clear) r_run <= w_strobe ? RUN_W'(1) : '0;
      else              r_run <= w_run_inc;

      if (w_fail_set)   r_fail <= 1'b1;
      else if (i_clear) r_fail <= 1'b0;

      if (!i_en || w_fail_set || r_fail) r_half <= 1'b0;
      else if (w_qual && i_mode) begin
        r_half <= ~w_half;
        if (!w_half) r_stored <= i_bit;
      end else if (i_mode_chg || !i_mode) r_half <= 1'b0;

      if (!i_en || w_fail_set) r_cand_valid <= 1'b0;
      else if (i_grant || !r_cand_valid) begin
        r_cand_valid <= w_prod;
        if (w_prod) r_cand_bit <= w_prod_bit;
      end

      r_drop <= w_prod & r_cand_valid & ~i_grant;
    end
  end

  assign o_cand_valid = r_cand_valid;
  assign o_cand_bit   = r_cand_bit;
  assign o_fail       = r_fail;
  assign o_drop       = r_drop;
endmodule

module trng_vn_packer #(
  parameter int CHANNELS   = 4,
  parameter int WORD_W     = 8,
  parameter int FIFO_DEPTH = 4,   // power of two, >= 2
  parameter int REP_LIMIT  = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                mode,
  input  logic [CHANNELS-1:0] ch_enable,
  input  logic [CHANNELS-1:0] raw_valid,
  input  logic [CHANNELS-1:0] raw_bit,
  input  logic                clear_fail,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WORD_W-1:0]   out_word,
  output logic [CHANNELS-1:0] health_fail,
  output logic                dropped
);
  localparam int CNT_W = $clog2(WORD_W + 1);
  localparam int PTR_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);

  logic                r_mode_q;
  logic [PTR_W-1:0]    r_ptr;
  logic [CNT_W-1:0]    r_cnt;
  logic [WORD_W-1:0]   r_data;
  logic [AW:0]         r_wp, r_rp;
  logic [WORD_W-1:0]   r_mem [FIFO_DEPTH];

  logic                w_mode_chg, w_stall, w_gv, w_gbit, w_word_done, w_push, w_pop;
  logic                w_empty, w_full;
  logic [PTR_W-1:0]    w_gidx;
  logic [PTR_W:0]      w_idx;
  logic [CHANNELS-1:0] w_cv, w_cb, w_grant, w_drop;
  logic [WORD_W-1:0]   w_data_nxt;

  assign w_mode_chg = mode ^ r_mode_q;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    trng_vn_lane #(.REP_LIMIT(REP_LIMIT)) u_lane (
      .clk(clk), .reset_n(reset_n), .i_mode(mode), .i_mode_chg(w_mode_chg),
      .i_en(ch_enable[g]), .i_valid(raw_valid[g]), .i_bit(raw_bit[g]),
      .i_clear(clear_fail), .i_grant(w_grant[g]),
      .o_cand_valid(w_cv[g]), .o_cand_bit(w_cb[g]), .o_fail(health_fail[g]),
      .o_drop(w_drop[g])
    );
  end

  // A completed word waiting on a full FIFO blocks all grants.
  assign w_stall = (r_cnt == CNT_W'(WORD_W));

  // Round-robin: first valid candidate at or after r_ptr, wrapping.
  always_comb begin
    w_gv    = 1'b0;
    w_gidx  = '0;
    w_idx   = '0;
    w_grant = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      w_idx = {1'b0, r_ptr} + (PTR_W+1)'(k);
      if (w_idx >= (PTR_W+1)'(CHANNELS)) w_idx = w_idx - (PTR_W+1)'(CHANNELS);
      if (!w_gv && !w_stall && w_cv[PTR_W'(w_idx)]) begin
        w_gv   = 1'b1;
        w_gidx = PTR_W'(w_idx);
      end
    end
    if (w_gv) w_grant[w_gidx] = 1'b1;
  end
  assign w_gbit = w_cb[w_gidx];

  always_comb begin
    w_data_nxt = r_data;
    for (int b = 0; b < WORD_W; b++)
      if (w_gv && r_cnt == CNT_W'(b)) w_data_nxt[b] = w_gbit;
  end

  assign w_empty     = (r_wp == r_rp);
  assign w_full      = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_pop       = out_valid & out_ready;
  assign w_word_done = w_stall | (w_gv & (r_cnt == CNT_W'(WORD_W - 1)));
  // Popping frees the slot this same edge, so push-while-full is lossless.
  assign w_push      = w_word_done & (~w_full | w_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mode_q <= 1'b0;
      r_ptr    <= '0;
      r_cnt    <= '0;
      r_data   <= '0;
      r_wp     <= '0;
      r_rp     <= '0;
    end else begin
      r_mode_q <= mode;
      if (w_gv) r_ptr <= (w_gidx == PTR_W'(CHANNELS - 1)) ? '0 : w_gidx + 1'b1;
      if (w_push) begin
        r_cnt  <= '0;
        r_data <= '0;
      end else if (w_gv) begin
        r_cnt  <= r_cnt + 1'b1;
        r_data <= w_data_nxt;
      end
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp[AW-1:0]] <= w_data_nxt;
  end

  assign out_valid = ~w_empty;
  assign out_word  = w_empty ? '0 : r_mem[r_rp[AW-1:0]];
  assign dropped   = |w_drop;
endmodule

// File: doc/trng_vn_packer.md
TRNG_VN_PACKER -- requirements
Module: trng_vn_packer

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, number of raw entropy channels.
REQ-002 SHALL have parameter WORD_W, default 8, packed output word width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, output word FIFO depth (power of two).
REQ-004 SHALL have parameter REP_LIMIT, default 32, repetition-count health threshold (>=2).
REQ-005 clk  input  1  sole clock; all state on rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 mode  input  1  0 = bypass, 1 = von Neumann debias.
REQ-008 ch_enable  input  CHANNELS  per-channel enable.
REQ-009 raw_valid  input  CHANNELS  per-channel raw bit strobe (latched bit present this cycle).
REQ-010 raw_bit  input  CHANNELS  per-channel raw bit.
REQ-011 clear_fail  input  1  clears all health_fail bits.
REQ-012 out_valid  output  1  FIFO non-empty.
REQ-013 out_ready  input  1  consumer accepts out_word.
REQ-014 out_word  output  WORD_W  FIFO head word.
REQ-015 health_fail  output  CHANNELS  sticky per-channel repetition failure.
REQ-016 dropped  output  1  one-cycle pulse when any debiased bit is lost to backpressure.

Function
REQ-017 Each channel SHALL hold pair state EMPTY/HALF plus one stored bit; only raw_valid&ch_enable&!health_fail advances it.
REQ-018 mode=1: EMPTY -> store bit, go HALF; HALF -> if stored!=new, produce candidate = stored bit; always return EMPTY (00/11 discarded).
REQ-019 mode=0: every qualifying raw bit SHALL become a candidate directly; pair state held EMPTY.
REQ-020 Each channel SHALL have a one-bit candidate register (cand_valid, cand_bit); candidate appears the cycle after the producing raw bit.
REQ-021 Merger SHALL grant at most one cand_valid per cycle, round-robin: lowest index at or after pointer, wrapping; pointer <- granted+1 mod CHANNELS; no grant -> pointer unchanged.
REQ-022 Granted bit SHALL enter packer at bit position = count (first bit -> out_word[0]); count increments.
REQ-023 When count reaches WORD_W the word SHALL push into FIFO the same edge if FIFO not full (or popped that cycle); out_valid visible next cycle; count -> 0.
REQ-024 Completed word with FIFO full SHALL be held; merger grants nothing until push succeeds.
REQ-025 Channel producing a new candidate while its cand_valid is set and not granted that cycle SHALL discard the new bit and pulse dropped next cycle.
REQ-026 FIFO SHALL pop on out_valid&out_ready; simultaneous push and pop when full SHALL be legal and lossless; out_word SHALL hold stable while out_valid&!out_ready.
REQ-027 Per channel, a run counter SHALL count consecutive identical raw bits (raw_valid&ch_enable, any mode); count starts at 1 on a differing bit.
REQ-028 Run count reaching REP_LIMIT SHALL set health_fail[i] next edge; failed channel's pair state -> EMPTY, cand_valid cleared, no dropped pulse.
REQ-029 clear_fail SHALL clear all health_fail and run counters; a set on the same cycle SHALL win.
REQ-030 ch_enable[i] low SHALL force pair EMPTY, run counter 0, cand_valid[i] 0 within one cycle.
REQ-031 Any change of mode SHALL flush all pair states to EMPTY; candidates, packer, FIFO retained.

Reset
REQ-032 reset_n low SHALL asynchronously clear: pair states EMPTY, cand_valid, pointer 0, packer count and data 0, FIFO empty, out_valid 0, out_word 0, health_fail 0, run counters 0, dropped 0.
REQ-033 Reset mid-word SHALL discard partial word and FIFO contents; first post-reset bit lands in out_word[0].

Verification
REQ-034 mode=1, ch0 only, raw 0,1,1,0,0,0,1,1 repeated -> bits 0,1 per 8 raw; after 32 raw, out_word=8'hAA, out_valid=1.
REQ-035 mode=0, 4 channels valid every cycle, bits ch0..3 = 1,0,0,0, out_ready=1 -> grants 0,1,2,3 rotate; each word 8'h11; dropped pulses every cycle after the first.
REQ-036 out_ready=0, mode=0, ch0 only -> FIFO holds 4 words, then merger stalls, dropped pulses; out_ready=1 -> words emerge in push order, none corrupted.
REQ-037 ch1 raw constant 1 for 32 valid strobes, REP_LIMIT=32 -> health_fail=4'b0010 next cycle, ch1 contributes no bits; clear_fail -> 4'b0000.
REQ-038 reset_n pulsed low after 5 packed bits with 2 FIFO words -> out_valid=0 immediately; next 8 bits form a fresh word.
REQ-039 mode toggled while ch0 HALF -> stored bit discarded; next pair alone decides output.
